// File: rtl/mipi_csi_pkg.sv
// Shared constants for the CSI-2 packet parser: data types, FSM states, ECC masks, CRC setup.
// Latency: n/a (package).
// Backpressure: n/a (package).
package mipi_csi_pkg;

  localparam logic [5:0] DT_FS    = 6'h00;
  localparam logic [5:0] DT_FE    = 6'h01;
  localparam logic [5:0] DT_LS    = 6'h02;
  localparam logic [5:0] DT_LE    = 6'h03;
  localparam logic [5:0] DT_RAW8  = 6'h2A;
  localparam logic [5:0] DT_RAW10 = 6'h2B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_CRC,
    ST_SKIP
  } state_t;

  // Parity masks over {WC MSB, WC LSB, DI}; entry i produces ECC bit i.
  localparam logic [5:0][23:0] ECC_MASK = {
    24'hEFFC00, 24'hDF03F0, 24'hB8E38E, 24'h749A6D, 24'hF2555B, 24'hF12CB7
  };

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h8408;

  function automatic logic [5:0] ecc_calc(input logic [23:0] d);
    logic [5:0] p;
    for (int i = 0; i < 6; i++) p[i] = ^(d & ECC_MASK[i]);
    return p;
  endfunction

endpackage

// File: rtl/mipi_csi_crc16.sv
// Running CRC-16 (reflected 0x8408) over payload bytes, one byte per clock.
// Latency: crc reflects a byte one cycle after it is presented with en.
// Backpressure: none; consumes data whenever en is high.
module mipi_csi_crc16
  import mipi_csi_pkg::*;
(
  input  logic        clk,
  input  logic        resetb,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_next;

  // Fold one byte into the current CRC, least-significant bit first
  always_comb begin
    crc_next = crc;
    for (int i = 0; i < 8; i++) begin
      if (crc_next[0] ^ data[i]) crc_next = (crc_next >> 1) ^ CRC_POLY;
      else                       crc_next = crc_next >> 1;
    end
  end

  // Accumulator register; a clear starts a new packet and wins over enable
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)  crc <= '0;
    else if (clr) crc <= CRC_INIT;
    else if (en)  crc <= crc_next;
  end

endmodule

// File: rtl/mipi_csi_pkt_parser.sv
// CSI-2 packet parser: header/ECC check, sync pulses, payload forwarding, CRC check.
// Latency: all outputs registered, one cycle after the byte that causes them.
// Backpressure: none; the PHY stream cannot stall, a falling in_we ends the burst.
module mipi_csi_pkt_parser
  import mipi_csi_pkg::*;
#(
  parameter bit         CHECK_CRC       = 1'b1,
  parameter bit         DROP_ON_ECC_ERR = 1'b1,
  parameter logic [5:0] LONG_DT_MIN     = 6'h10
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        in_we,
  input  logic [7:0]  in_data,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_start,
  output logic        line_end,
  output logic [1:0]  vc,
  output logic [5:0]  dt,
  output logic [15:0] word_count,
  output logic        pix_we,
  output logic [7:0]  pix_data,
  output logic        pix_last,
  output logic        pkt_done,
  output logic        ecc_err,
  output logic        crc_err,
  output logic        trunc_err
);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  di_q, di_d, wcl_q, wcl_d, wcm_q, wcm_d, crc_lo_q, crc_lo_d;
  logic [15:0] rem_q, rem_d;
  logic        ecc_bad_q, ecc_bad_d;

  logic        fs_d, fe_d, ls_d, le_d, pw_d, pl_d, done_d, ecc_d, crc_d, trunc_d;
  logic [1:0]  vc_d;
  logic [5:0]  dt_d;
  logic [15:0] wc_d;
  logic [7:0]  pd_d;

  logic        crc_clr, crc_en, ecc_bad;
  logic [15:0] crc_val, hdr_wc;

  mipi_csi_crc16 u_crc (
    .clk    (clk),
    .resetb (resetb),
    .clr    (crc_clr),
    .en     (crc_en),
    .data   (in_data),
    .crc    (crc_val)
  );

  assign hdr_wc  = {wcm_q, wcl_q};
  assign ecc_bad = (in_data != {2'b00, ecc_calc({wcm_q, wcl_q, di_q})});

  // Next-state and next-output decode; every output is a one-cycle pulse unless held below
  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;  di_d = di_q;  wcl_d = wcl_q;  wcm_d = wcm_q;
    crc_lo_d = crc_lo_q;  rem_d = rem_q;  ecc_bad_d = ecc_bad_q;
    vc_d = vc;  dt_d = dt;  wc_d = word_count;  pd_d = pix_data;
    fs_d = 1'b0;  fe_d = 1'b0;  ls_d = 1'b0;  le_d = 1'b0;
    pw_d = 1'b0;  pl_d = 1'b0;  done_d = 1'b0;
    ecc_d = 1'b0;  crc_d = 1'b0;  trunc_d = 1'b0;
    crc_clr = 1'b0;  crc_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_we) begin
          di_d = in_data;  cnt_d = 2'd0;  ecc_bad_d = 1'b0;  crc_clr = 1'b1;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (!in_we) begin
          done_d = 1'b1;  trunc_d = 1'b1;  state_d = ST_IDLE;
        end else if (cnt_q == 2'd0) begin
          wcl_d = in_data;  cnt_d = 2'd1;
        end else if (cnt_q == 2'd1) begin
          wcm_d = in_data;  cnt_d = 2'd2;
        end else begin
          vc_d = di_q[7:6];  dt_d = di_q[5:0];  wc_d = hdr_wc;
          rem_d = hdr_wc;  ecc_bad_d = ecc_bad;  cnt_d = 2'd0;
          if (ecc_bad && DROP_ON_ECC_ERR) begin
            done_d = 1'b1;  ecc_d = 1'b1;  state_d = ST_SKIP;
          end else if (di_q[5:0] < LONG_DT_MIN) begin
            fs_d = (di_q[5:0] == DT_FS);  fe_d = (di_q[5:0] == DT_FE);
            ls_d = (di_q[5:0] == DT_LS);  le_d = (di_q[5:0] == DT_LE);
            done_d = 1'b1;  ecc_d = ecc_bad;  state_d = ST_SKIP;
          end else if (hdr_wc == 16'd0) begin
            state_d = ST_CRC;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (!in_we) begin
          done_d = 1'b1;  trunc_d = 1'b1;  ecc_d = ecc_bad_q;  state_d = ST_IDLE;
        end else begin
          pw_d = 1'b1;  pd_d = in_data;  crc_en = 1'b1;  rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            pl_d = 1'b1;  state_d = ST_CRC;
          end
        end
      end
      ST_CRC: begin
        if (!in_we) begin
          done_d = 1'b1;  trunc_d = 1'b1;  ecc_d = ecc_bad_q;  state_d = ST_IDLE;
        end else if (cnt_q == 2'd0) begin
          crc_lo_d = in_data;  cnt_d = 2'd1;
        end else begin
          done_d = 1'b1;  ecc_d = ecc_bad_q;
          crc_d = CHECK_CRC && ({in_data, crc_lo_q} != crc_val);
          state_d = ST_SKIP;
        end
      end
      ST_SKIP: begin
        if (!in_we) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, working registers and registered outputs
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_IDLE;  cnt_q <= '0;  di_q <= '0;  wcl_q <= '0;  wcm_q <= '0;
      crc_lo_q <= '0;  rem_q <= '0;  ecc_bad_q <= 1'b0;
      frame_start <= 1'b0;  frame_end <= 1'b0;  line_start <= 1'b0;  line_end <= 1'b0;
      vc <= '0;  dt <= '0;  word_count <= '0;
      pix_we <= 1'b0;  pix_data <= '0;  pix_last <= 1'b0;
      pkt_done <= 1'b0;  ecc_err <= 1'b0;  crc_err <= 1'b0;  trunc_err <= 1'b0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  di_q <= di_d;  wcl_q <= wcl_d;  wcm_q <= wcm_d;
      crc_lo_q <= crc_lo_d;  rem_q <= rem_d;  ecc_bad_q <= ecc_bad_d;
      frame_start <= fs_d;  frame_end <= fe_d;  line_start <= ls_d;  line_end <= le_d;
      vc <= vc_d;  dt <= dt_d;  word_count <= wc_d;
      pix_we <= pw_d;  pix_data <= pd_d;  pix_last <= pl_d;
      pkt_done <= done_d;  ecc_err <= ecc_d;  crc_err <= crc_d;  trunc_err <= trunc_d;
    end
  end

endmodule

// File: tb/tb_mipi_csi_pkt_parser.sv
// Bench for mipi_csi_pkt_parser: packet-level model, per-cycle compare, directed bursts.
// Latency: model expects outputs one cycle after the causing byte.
// Backpressure: none; bursts are driven back to back with idle gaps.
module tb_mipi_csi_pkt_parser;

  localparam int NC  = 1024;
  localparam int GAP = 3;

  logic        clk, resetb, in_we;
  logic [7:0]  in_data;
  logic        frame_start, frame_end, line_start, line_end;
  logic [1:0]  vc;
  logic [5:0]  dt;
  logic [15:0] word_count;
  logic        pix_we, pix_last, pkt_done, ecc_err, crc_err, trunc_err;
  logic [7:0]  pix_data;

  logic        nc_fs, nc_fe, nc_ls, nc_le, nc_pix_we, nc_pix_last, nc_pkt_done;
  logic        nc_ecc_err, nc_crc_err, nc_trunc_err;
  logic [1:0]  nc_vc;
  logic [5:0]  nc_dt;
  logic [15:0] nc_wc;
  logic [7:0]  nc_pix_data;

  mipi_csi_pkt_parser dut (
    .clk(clk), .resetb(resetb), .in_we(in_we), .in_data(in_data),
    .frame_start(frame_start), .frame_end(frame_end), .line_start(line_start), .line_end(line_end),
    .vc(vc), .dt(dt), .word_count(word_count),
    .pix_we(pix_we), .pix_data(pix_data), .pix_last(pix_last),
    .pkt_done(pkt_done), .ecc_err(ecc_err), .crc_err(crc_err), .trunc_err(trunc_err)
  );

  mipi_csi_pkt_parser #(.CHECK_CRC(1'b0)) dut_nc (
    .clk(clk), .resetb(resetb), .in_we(in_we), .in_data(in_data),
    .frame_start(nc_fs), .frame_end(nc_fe), .line_start(nc_ls), .line_end(nc_le),
    .vc(nc_vc), .dt(nc_dt), .word_count(nc_wc),
    .pix_we(nc_pix_we), .pix_data(nc_pix_data), .pix_last(nc_pix_last),
    .pkt_done(nc_pkt_done), .ecc_err(nc_ecc_err), .crc_err(nc_crc_err), .trunc_err(nc_trunc_err)
  );

  typedef struct packed {
    logic        fs, fe, ls, le;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic        pw;
    logic [7:0]  pd;
    logic        pl, done, ecc, crc, trunc;
  } exp_t;

  exp_t        exp_q [NC];
  bit          chk_en[NC];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [1:0]  m_vc;
  logic [5:0]  m_dt;
  logic [15:0] m_wc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // CSI-2 header ECC written out as the parity equations, D0 = DI bit 0
  function automatic logic [7:0] ecc_of(input logic [7:0] di, input logic [7:0] lsb,
                                        input logic [7:0] msb);
    logic [23:0] d;
    logic [5:0]  p;
    d = {msb, lsb, di};
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return {2'b00, p};
  endfunction

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int j = 0; j < 8; j++) r = (r[0] ^ b[j]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  // Packet-level model: turns one burst into the expected output of every cycle it spans
  task automatic plan(input int base, input int n, input logic [7:0] b[16]);
    exp_t        e;
    logic [1:0]  nvc;
    logic [5:0]  ndt;
    logic [15:0] nwc, c;
    logic        ok;
    int          wc, p;
    nvc = b[0][7:6];  ndt = b[0][5:0];  nwc = {b[2], b[1]};
    for (int i = 0; i <= n + GAP; i++) begin
      e = '0;
      if (n >= 4 && i >= 3) begin e.vc = nvc; e.dt = ndt; e.wc = nwc; end
      else begin e.vc = m_vc; e.dt = m_dt; e.wc = m_wc; end
      exp_q[base + i] = e;
      chk_en[base + i] = 1'b1;
    end
    if (n < 4) begin
      exp_q[base + n].done = 1'b1;  exp_q[base + n].trunc = 1'b1;
    end else begin
      ok = (b[3] == ecc_of(b[0], b[1], b[2]));
      m_vc = nvc;  m_dt = ndt;  m_wc = nwc;
      if (!ok) begin
        exp_q[base + 3].done = 1'b1;  exp_q[base + 3].ecc = 1'b1;
      end else if (ndt < 6'h10) begin
        exp_q[base + 3].fs = (ndt == 6'h00);  exp_q[base + 3].fe = (ndt == 6'h01);
        exp_q[base + 3].ls = (ndt == 6'h02);  exp_q[base + 3].le = (ndt == 6'h03);
        exp_q[base + 3].done = 1'b1;
      end else begin
        wc = int'(nwc);
        p = (n - 4 < wc) ? n - 4 : wc;
        c = 16'hFFFF;
        for (int k = 0; k < p; k++) begin
          exp_q[base + 4 + k].pw = 1'b1;
          exp_q[base + 4 + k].pd = b[4 + k];
          exp_q[base + 4 + k].pl = (k == wc - 1);
          c = crc_byte(c, b[4 + k]);
        end
        if (n < 6 + wc) begin
          exp_q[base + n].done = 1'b1;  exp_q[base + n].trunc = 1'b1;
        end else begin
          exp_q[base + 5 + wc].done = 1'b1;
          exp_q[base + 5 + wc].crc = (c != {b[5 + wc], b[4 + wc]});
        end
      end
    end
  endtask

  // Drive one HS burst (first byte in the most significant position of v); call at a negedge
  task automatic send(input int n, input logic [127:0] v);
    logic [7:0] b[16];
    int         base;
    for (int i = 0; i < 16; i++) begin
      b[i] = 8'h00;
      if (i < n) b[i] = v[8*(n-1-i) +: 8];
    end
    base = cyc + 1;
    plan(base, n, b);
    for (int i = 0; i < n; i++) begin
      in_we = 1'b1;  in_data = b[i];
      @(negedge clk);
    end
    in_we = 1'b0;  in_data = 8'h00;
    repeat (GAP + 1) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sync"}, {frame_start, frame_end, line_start, line_end}, 0);
    chk({tag, "_vc"}, vc, 0);
    chk({tag, "_dt"}, dt, 0);
    chk({tag, "_wc"}, word_count, 0);
    chk({tag, "_pix"}, {pix_we, pix_last, pix_data}, 0);
    chk({tag, "_done"}, {pkt_done, ecc_err, crc_err, trunc_err}, 0);
  endtask

  // Per-cycle comparison against the model wherever a burst window was planned
  always @(negedge clk) begin
    exp_t e;
    if (resetb && cyc < NC && chk_en[cyc]) begin
      e = exp_q[cyc];
      chk("frame_start", frame_start, e.fs);
      chk("frame_end", frame_end, e.fe);
      chk("line_start", line_start, e.ls);
      chk("line_end", line_end, e.le);
      chk("vc", vc, e.vc);
      chk("dt", dt, e.dt);
      chk("word_count", word_count, e.wc);
      chk("pix_we", pix_we, e.pw);
      chk("pix_last", pix_last, e.pl);
      chk("pkt_done", pkt_done, e.done);
      chk("nc_pix_we", nc_pix_we, e.pw);
      if (e.pw) chk("pix_data", pix_data, e.pd);
      if (e.done || pkt_done) begin
        chk("ecc_err", ecc_err, e.ecc);
        chk("crc_err", crc_err, e.crc);
        chk("trunc_err", trunc_err, e.trunc);
      end
      if (e.done || nc_pkt_done) begin
        chk("nc_pkt_done", nc_pkt_done, e.done);
        chk("nc_crc_err", nc_crc_err, 1'b0);
      end
    end
  end

  initial begin
    string       s;
    logic [15:0] c;
    logic [7:0]  e8;
    resetb = 1'b0;  in_we = 1'b0;  in_data = 8'h00;
    m_vc = '0;  m_dt = '0;  m_wc = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    resetb = 1'b1;
    @(negedge clk);

    // Pin the model helpers against hand-derived values
    chk("pin_ecc_ls", ecc_of(8'h02, 8'h00, 8'h00), 8'h0B);
    chk("pin_ecc_raw8", ecc_of(8'h2A, 8'h04, 8'h00), 8'h33);
    s = "123456789";
    c = 16'hFFFF;
    for (int i = 0; i < 9; i++) c = crc_byte(c, s[i]);
    chk("pin_crc_check", c, 16'h6F91);

    send(4, {8'h00, 8'h00, 8'h00, 8'h00});
    send(4, {8'h00, 8'h01, 8'h00, 8'h00});
    send(4, {8'h02, 8'h00, 8'h00, 8'h0B});
    send(4, {8'h01, 8'h00, 8'h00, ecc_of(8'h01, 8'h00, 8'h00)});
    send(6, {8'hC3, 8'h34, 8'h12, ecc_of(8'hC3, 8'h34, 8'h12), 8'h55, 8'h66});
    send(4, {8'h05, 8'h00, 8'h00, ecc_of(8'h05, 8'h00, 8'h00)});

    c = 16'hFFFF;
    c = crc_byte(c, 8'h11);  c = crc_byte(c, 8'h22);
    c = crc_byte(c, 8'h33);  c = crc_byte(c, 8'h44);
    send(10, {8'h2A, 8'h04, 8'h00, 8'h33, 8'h11, 8'h22, 8'h33, 8'h44, c[7:0], c[15:8]});
    send(10, {8'h2A, 8'h04, 8'h00, 8'h33, 8'h11, 8'h22, 8'h33, 8'h44,
              c[7:0] ^ 8'h01, c[15:8]});

    e8 = ecc_of(8'h2A, 8'h08, 8'h00);
    send(7, {8'h2A, 8'h08, 8'h00, e8, 8'hA0, 8'hA1, 8'hA2});
    send(4, {8'h00, 8'h00, 8'h00, 8'h00});

    e8 = ecc_of(8'h2A, 8'h00, 8'h00);
    send(11, {8'h2A, 8'h00, 8'h00, e8, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
    send(2, {8'h2A, 8'h04});
    e8 = ecc_of(8'h6B, 8'h02, 8'h00);
    send(7, {8'h6B, 8'h02, 8'h00, e8, 8'h5A, 8'hA5, 8'h12});

    // Reset asserted while payload is streaming
    e8 = ecc_of(8'h6A, 8'h04, 8'h00);
    in_we = 1'b1;  in_data = 8'h6A;  @(negedge clk);
    in_data = 8'h04;  @(negedge clk);
    in_data = 8'h00;  @(negedge clk);
    in_data = e8;     @(negedge clk);
    in_data = 8'h11;  @(negedge clk);
    in_data = 8'h22;  @(negedge clk);
    chk("pre_reset_pix_we", pix_we, 1'b1);
    chk("pre_reset_vc", vc, 2'd1);
    #1;
    resetb = 1'b0;  in_we = 1'b0;  in_data = 8'h00;
    #1;
    check_zero("mid_reset");
    @(negedge clk);
    resetb = 1'b1;
    m_vc = '0;  m_dt = '0;  m_wc = '0;
    @(negedge clk);
    send(4, {8'h00, 8'h00, 8'h00, 8'h00});
    send(4, {8'h03, 8'h00, 8'h00, ecc_of(8'h03, 8'h00, 8'h00)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
